// File: rtl/dac_pwmds_mc.sv
//----------------------------------------------------------------------------
// dac_pwmds_mc
//
// Multi-channel PWM + first-order delta-sigma audio DAC. Each channel holds
// one signed sample. Once per PWM frame (L = 2^PWM_BITS clocks) the
// modulator turns the sample plus the carried error into a duty level q.
// The 1-bit output of that channel is high for the first q clocks of the
// next frame. The residue below one quantiser step S = 2^(DW-PWM_BITS) is
// carried to the next frame. A soft-mute FSM (RUN / MUTING / MUTED) halves
// the held samples on every frame until they reach zero. Saturation sets a
// sticky flag for each channel.
//
// Optional feature: define DAC_PWMDS_DITHER_EN to add a shared 16-bit LFSR.
// The LFSR gives a uniform +/-S/8 dither that is added on every frame.
//
// Ports:
//   dac_clk      in   clock
//   dac_rst_n    in   asynchronous active-low reset
//   dac_data     in   CH*DW packed signed samples, channel n at [n*DW +: DW]
//   dac_req      in   one-cycle sample strobe
//   dac_mute     in   level, request soft mute
//   dac_ovf_clr  in   clear all overflow flags
//   dac_out      out  CH bitstreams
//   dac_tick     out  one-cycle strobe at the start of every frame
//   dac_ovf      out  CH sticky saturation flags
//   dac_muted    out  high while in MUTED
//----------------------------------------------------------------------------
module dac_pwmds_mc #(
   parameter int CH       = 2,
   parameter int DW       = 20,
   parameter int PWM_BITS = 3
) (
   input  logic               dac_clk,
   input  logic               dac_rst_n,
   input  logic [CH*DW-1:0]   dac_data,
   input  logic               dac_req,
   input  logic               dac_mute,
   input  logic               dac_ovf_clr,
   output logic [CH-1:0]      dac_out,
   output logic               dac_tick,
   output logic [CH-1:0]      dac_ovf,
   output logic               dac_muted
);

   localparam int SH = DW - PWM_BITS;   // log2 of the quantiser step
   localparam int UW = DW + 2;          // modulator accumulator width

   localparam logic [UW-1:0] MID = UW'(1) << (DW - 1);

   typedef enum logic [1:0] {ST_RUN, ST_MUTING, ST_MUTED} state_t;

   state_t               state_q, state_d;
   logic [PWM_BITS-1:0]  phase_q, phase_d;
   logic signed [DW-1:0] x_q [CH];
   logic signed [DW-1:0] x_d [CH];
   logic signed [DW-1:0] xs  [CH];
   logic [SH-1:0]        e_q [CH];
   logic [SH-1:0]        e_d [CH];
   logic [PWM_BITS-1:0]  q_q [CH];
   logic [PWM_BITS-1:0]  q_d [CH];
   logic [UW-1:0]        u   [CH];
   logic [CH-1:0]        out_q, out_d;
   logic [CH-1:0]        ovf_q, ovf_d;
   logic                 tick_q, tick_d;
   logic                 muted_q, muted_d;
   logic                 tick_edge;
   logic                 all_small;
   logic [UW-1:0]        dith;

   // The modulator and the mute shifts act on the last clock of each frame.
   assign tick_edge = (phase_q == {PWM_BITS{1'b1}});

`ifdef DAC_PWMDS_DITHER_EN
   localparam int DB = SH - 2;   // dither slice width, lfsr[SH-3:0]
   localparam logic [UW-1:0] DITH_OFS = UW'(1) << (DB - 1);

   logic [15:0] lfsr_q, lfsr_d;

   // Fibonacci LFSR with taps 16,14,13,11. It steps once per frame.
   always_comb begin
      lfsr_d = lfsr_q;
      if (tick_edge) begin
         lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   always_ff @(posedge dac_clk or negedge dac_rst_n) begin
      if (!dac_rst_n) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   // Centre the slice on zero to give a uniform dither of +/-S/8.
   assign dith = {{(UW-DB){1'b0}}, lfsr_q[DB-1:0]} - DITH_OFS;
`else
   assign dith = '0;
`endif

   always_comb begin
      phase_d   = phase_q + PWM_BITS'(1);
      tick_d    = tick_edge;
      state_d   = state_q;
      ovf_d     = ovf_q & ~{CH{dac_ovf_clr}};
      all_small = 1'b1;

      for (int n = 0; n < CH; n++) begin
         x_d[n] = x_q[n];
         e_d[n] = e_q[n];
         q_d[n] = q_q[n];
         xs[n]  = x_q[n] >>> 1;
         if ((xs[n] != '0) && (xs[n] != '1)) begin
            all_small = 1'b0;
         end

         // The offset sample plus the carried error plus dither is never
         // negative without dither. The top two bits are zero exactly when
         // u / S lands in 0..L-1. Otherwise the level saturates.
         u[n] = {{2{x_q[n][DW-1]}}, x_q[n]} + MID + {{(UW-SH){1'b0}}, e_q[n]} + dith;
         if (tick_edge) begin
            if (u[n][UW-1:DW] == 2'b00) begin
               q_d[n] = u[n][DW-1:SH];
               e_d[n] = u[n][SH-1:0];
            end else begin
               q_d[n]   = u[n][UW-1] ? {PWM_BITS{1'b0}} : {PWM_BITS{1'b1}};
               e_d[n]   = '0;
               ovf_d[n] = 1'b1;
            end
         end
      end

      // Mute control. A request to leave mute is checked on every clock.
      // The halving steps happen only on frame boundaries.
      case (state_q)
         ST_RUN: begin
            if (dac_req) begin
               for (int n = 0; n < CH; n++) begin
                  x_d[n] = dac_data[n*DW +: DW];
               end
            end
            if (dac_mute) begin
               state_d = ST_MUTING;
            end
         end
         ST_MUTING: begin
            if (!dac_mute) begin
               state_d = ST_RUN;
            end else if (tick_edge) begin
               for (int n = 0; n < CH; n++) begin
                  x_d[n] = all_small ? '0 : xs[n];
               end
               if (all_small) begin
                  state_d = ST_MUTED;
               end
            end
         end
         ST_MUTED: begin
            for (int n = 0; n < CH; n++) begin
               x_d[n] = '0;
            end
            if (!dac_mute) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase

      // The outputs are computed from the next phase and level. This lets
      // each registered bit line up with the phase held in the same cycle.
      for (int n = 0; n < CH; n++) begin
         out_d[n] = (phase_d < q_d[n]);
      end
      muted_d = (state_d == ST_MUTED);
   end

   always_ff @(posedge dac_clk or negedge dac_rst_n) begin
      if (!dac_rst_n) begin
         phase_q <= '0;
         state_q <= ST_RUN;
         tick_q  <= 1'b0;
         out_q   <= '0;
         ovf_q   <= '0;
         muted_q <= 1'b0;
         for (int n = 0; n < CH; n++) begin
            x_q[n] <= '0;
            e_q[n] <= '0;
            q_q[n] <= '0;
         end
      end else begin
         phase_q <= phase_d;
         state_q <= state_d;
         tick_q  <= tick_d;
         out_q   <= out_d;
         ovf_q   <= ovf_d;
         muted_q <= muted_d;
         for (int n = 0; n < CH; n++) begin
            x_q[n] <= x_d[n];
            e_q[n] <= e_d[n];
            q_q[n] <= q_d[n];
         end
      end
   end

   assign dac_out   = out_q;
   assign dac_tick  = tick_q;
   assign dac_ovf   = ovf_q;
   assign dac_muted = muted_q;

endmodule

// File: tb/tb_dac_pwmds_mc.sv
//----------------------------------------------------------------------------
// tb_dac_pwmds_mc
//
// Self-checking bench for dac_pwmds_mc with the default build (no dither).
// A frame-level arithmetic model predicts every output on every cycle.
// Directed scenarios pin both the model and the DUT to hand-computed values.
//----------------------------------------------------------------------------
module tb_dac_pwmds_mc;

   localparam int     CH   = 2;
   localparam int     DW   = 20;
   localparam int     PB   = 3;
   localparam int     L    = 8;
   localparam longint S    = 131072;
   localparam longint HALF = 524288;
   localparam int     M_RUN = 0, M_MUTING = 1, M_MUTED = 2;

   logic               dac_clk     = 1'b0;
   logic               dac_rst_n   = 1'b0;
   logic [CH*DW-1:0]   dac_data;
   logic               dac_req     = 1'b0;
   logic               dac_mute    = 1'b0;
   logic               dac_ovf_clr = 1'b0;
   logic [CH-1:0]      dac_out;
   logic               dac_tick;
   logic [CH-1:0]      dac_ovf;
   logic               dac_muted;

   longint din [CH];
   int     checks = 0;
   int     errors = 0;
   bit     cmp_en = 1'b1;

   // Behavioural model state
   longint        m_x [CH];
   longint        m_e [CH];
   int            m_q [CH];
   int            m_phase = 0;
   int            m_age   = 0;
   int            m_state = M_RUN;
   logic [CH-1:0] m_ovf   = '0;

   dac_pwmds_mc #(.CH(CH), .DW(DW), .PWM_BITS(PB)) dut (
      .dac_clk     (dac_clk),
      .dac_rst_n   (dac_rst_n),
      .dac_data    (dac_data),
      .dac_req     (dac_req),
      .dac_mute    (dac_mute),
      .dac_ovf_clr (dac_ovf_clr),
      .dac_out     (dac_out),
      .dac_tick    (dac_tick),
      .dac_ovf     (dac_ovf),
      .dac_muted   (dac_muted)
   );

   always #5 dac_clk = ~dac_clk;

   always_comb begin
      for (int n = 0; n < CH; n++) begin
         dac_data[n*DW +: DW] = din[n][DW-1:0];
      end
   end

   function automatic longint fdiv(longint a, longint b);
      return (a >= 0) ? a / b : -((-a + b - 1) / b);
   endfunction

   task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual=%0d required=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Frame-level reference. Each frame, level = floor(total / S) and the
   // remainder is carried. The mute halves the samples by floor division.
   longint        nx [CH];
   longint        ne [CH];
   int            nq [CH];
   longint        u, qr;
   logic [CH-1:0] nov;
   int            ns;
   bit            tick_edge, all_small;

   always @(posedge dac_clk or negedge dac_rst_n) begin
      if (!dac_rst_n) begin
         m_phase <= 0;
         m_age   <= 0;
         m_state <= M_RUN;
         m_ovf   <= '0;
         for (int n = 0; n < CH; n++) begin
            m_x[n] <= 0;
            m_e[n] <= 0;
            m_q[n] <= 0;
         end
      end else begin
         tick_edge = (m_phase == L - 1);
         nov = m_ovf & ~{CH{dac_ovf_clr}};
         for (int n = 0; n < CH; n++) begin
            nx[n] = m_x[n];
            ne[n] = m_e[n];
            nq[n] = m_q[n];
            if (tick_edge) begin
               u  = m_x[n] + HALF + m_e[n];
               qr = fdiv(u, S);
               if (qr >= 0 && qr <= L - 1) begin
                  nq[n] = int'(qr);
                  ne[n] = u - qr * S;
               end else begin
                  nq[n]  = (u < 0) ? 0 : L - 1;
                  ne[n]  = 0;
                  nov[n] = 1'b1;
               end
            end
         end
         ns = m_state;
         if (m_state == M_RUN) begin
            if (dac_req) for (int n = 0; n < CH; n++) nx[n] = din[n];
            if (dac_mute) ns = M_MUTING;
         end else if (m_state == M_MUTING) begin
            if (!dac_mute) ns = M_RUN;
            else if (tick_edge) begin
               all_small = 1'b1;
               for (int n = 0; n < CH; n++) begin
                  nx[n] = fdiv(m_x[n], 2);
                  if (nx[n] != 0 && nx[n] != -1) all_small = 1'b0;
               end
               if (all_small) begin
                  for (int n = 0; n < CH; n++) nx[n] = 0;
                  ns = M_MUTED;
               end
            end
         end else begin
            for (int n = 0; n < CH; n++) nx[n] = 0;
            if (!dac_mute) ns = M_RUN;
         end
         for (int n = 0; n < CH; n++) begin
            m_x[n] <= nx[n];
            m_e[n] <= ne[n];
            m_q[n] <= nq[n];
         end
         m_state <= ns;
         m_ovf   <= nov;
         m_phase <= (m_phase + 1) % L;
         m_age   <= m_age + 1;
      end
   end

   // Compare every output against the model in the middle of each cycle.
   logic [CH-1:0] exp_out;
   always @(negedge dac_clk) begin
      if (cmp_en) begin
         for (int n = 0; n < CH; n++) exp_out[n] = (m_phase < m_q[n]);
         checkOutput("cyc_out", 64'(dac_out), 64'(exp_out));
         checkOutput("cyc_tick", 64'(dac_tick), 64'(m_phase == 0 && m_age > 0));
         checkOutput("cyc_ovf", 64'(dac_ovf), 64'(m_ovf));
         checkOutput("cyc_muted", 64'(dac_muted), 64'(m_state == M_MUTED));
      end
   end

   task automatic next_cycle();
      @(posedge dac_clk);
      #1;
   endtask

   task automatic applyStimulus(longint d0, longint d1);
      din[0]  = d0;
      din[1]  = d1;
      dac_req = 1'b1;
      next_cycle();
      dac_req = 1'b0;
   endtask

   task automatic wait_phase(int p);
      for (int i = 0; i < 2 * L && m_phase != p; i++) next_cycle();
      if (m_phase != p) checkOutput("wait_phase", 64'(m_phase), 64'(p));
   endtask

   task automatic wait_ticks(int k);
      int seen = 0;
      for (int i = 0; i < k * L + L && seen < k; i++) begin
         next_cycle();
         if (m_phase == 0) seen++;
      end
      if (seen != k) checkOutput("wait_ticks", 64'(seen), 64'(k));
   endtask

   task automatic frame_duty(int ch, output int cnt);
      cnt = 0;
      wait_phase(0);
      for (int i = 0; i < L; i++) begin
         @(negedge dac_clk);
         cnt += int'(dac_out[ch]);
         next_cycle();
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int d0, d1, d2, ticks;
      bit found;
      logic signed [DW-1:0] r;

      for (int n = 0; n < CH; n++) din[n] = 0;
      next_cycle();
      checkOutput("rst_out", 64'(dac_out), 64'd0);
      checkOutput("rst_tick", 64'(dac_tick), 64'd0);
      checkOutput("rst_ovf", 64'(dac_ovf), 64'd0);
      checkOutput("rst_muted", 64'(dac_muted), 64'd0);
      next_cycle();
      dac_rst_n = 1'b1;

      // Idle: x=0 gives half duty on both channels
      wait_ticks(2);
      frame_duty(0, d0);
      frame_duty(1, d1);
      checkOutput("idle_duty0", 64'(d0), 64'd4);
      checkOutput("idle_duty1", 64'(d1), 64'd4);
      checkOutput("idle_ovf", 64'(dac_ovf), 64'd0);

      // 262144 -> 6/8, -full scale -> constant low
      applyStimulus(262144, -524288);
      wait_ticks(2);
      checkOutput("m_q0_6", 64'(m_q[0]), 64'd6);
      checkOutput("m_e0_0", 64'(m_e[0]), 64'd0);
      frame_duty(0, d0);
      frame_duty(1, d1);
      checkOutput("duty0_6", 64'(d0), 64'd6);
      checkOutput("duty1_0", 64'(d1), 64'd0);

      // S/2 -> levels alternate 4,5,4 with error 65536,0
      applyStimulus(65536, -524288);
      wait_ticks(1);
      checkOutput("m_q0_4", 64'(m_q[0]), 64'd4);
      checkOutput("m_e0_65536", 64'(m_e[0]), 64'd65536);
      frame_duty(0, d0);
      frame_duty(0, d1);
      frame_duty(0, d2);
      checkOutput("alt_duty_a", 64'(d0), 64'd4);
      checkOutput("alt_duty_b", 64'(d1), 64'd5);
      checkOutput("alt_duty_c", 64'(d2), 64'd4);

      // +full scale: q=7/e=131071, then saturation sets the sticky flag
      applyStimulus(524287, 0);
      wait_ticks(1);
      checkOutput("fs_q7", 64'(m_q[0]), 64'd7);
      checkOutput("fs_e", 64'(m_e[0]), 64'd131071);
      checkOutput("fs_ovf_pre", 64'(dac_ovf), 64'd0);
      wait_ticks(1);
      checkOutput("fs_ovf_set", 64'(dac_ovf), 64'd1);
      checkOutput("fs_e_sat", 64'(m_e[0]), 64'd0);
      wait_ticks(3);
      checkOutput("fs_ovf_hold", 64'(dac_ovf), 64'd1);
      dac_ovf_clr = 1'b1;
      next_cycle();
      dac_ovf_clr = 1'b0;
      checkOutput("fs_ovf_clr", 64'(dac_ovf), 64'd0);
      // Assert the clear on the same edge as a saturating update
      found = 1'b0;
      for (int f = 0; f < 4 && !found; f++) begin
         wait_phase(L - 1);
         if (m_x[0] + HALF + m_e[0] >= L * S) begin
            dac_ovf_clr = 1'b1;
            found = 1'b1;
         end
         next_cycle();
         dac_ovf_clr = 1'b0;
      end
      checkOutput("setclr_found", 64'(found), 64'd1);
      checkOutput("setclr_ovf", 64'(dac_ovf), 64'd1);
      dac_ovf_clr = 1'b1;
      next_cycle();
      dac_ovf_clr = 1'b0;

      // Soft mute: 262144 halves to 0 on the 19th tick
      applyStimulus(262144, 0);
      wait_ticks(2);
      wait_phase(2);
      dac_mute = 1'b1;
      ticks = 0;
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge dac_clk);
         if (dac_tick) ticks++;
         if (dac_muted) found = 1'b1;
      end
      next_cycle();
      checkOutput("mute_reached", 64'(found), 64'd1);
      checkOutput("mute_ticks", 64'(ticks), 64'd19);
      checkOutput("mute_x0", 64'(m_x[0]), 64'd0);
      frame_duty(0, d0);
      checkOutput("mute_duty", 64'(d0), 64'd4);
      applyStimulus(262144, 262144);
      wait_ticks(2);
      frame_duty(0, d0);
      checkOutput("mute_req_ign", 64'(d0), 64'd4);
      dac_mute = 1'b0;
      next_cycle();
      checkOutput("unmute", 64'(dac_muted), 64'd0);
      applyStimulus(262144, -524288);
      wait_ticks(2);
      frame_duty(0, d0);
      frame_duty(1, d1);
      checkOutput("reload_duty0", 64'(d0), 64'd6);
      checkOutput("reload_duty1", 64'(d1), 64'd0);

      // Randomised traffic, checked every cycle against the model
      for (int i = 0; i < 3000; i++) begin
         dac_req = ($urandom_range(0, 9) == 0);
         for (int n = 0; n < CH; n++) begin
            if ($urandom_range(0, 3) == 0) begin
               case ($urandom_range(0, 3))
                  0: din[n] = -524288;
                  1: din[n] = 524287;
                  2: din[n] = 0;
                  default: din[n] = -1;
               endcase
            end else begin
               r = DW'($urandom);
               din[n] = r;
            end
         end
         if ($urandom_range(0, 199) == 0) dac_mute = ~dac_mute;
         dac_ovf_clr = ($urandom_range(0, 49) == 0);
         next_cycle();
      end
      dac_req = 1'b0;
      dac_mute = 1'b0;
      dac_ovf_clr = 1'b0;
      next_cycle();

      // Asynchronous reset mid-frame while the output is high
      applyStimulus(0, 0);
      wait_ticks(2);
      wait_phase(3);
      checkOutput("pre_rst_out", 64'(dac_out[0]), 64'd1);
      #1;
      dac_rst_n = 1'b0;
      #1;
      checkOutput("async_rst_out", 64'(dac_out), 64'd0);
      checkOutput("async_rst_tick", 64'(dac_tick), 64'd0);
      next_cycle();
      next_cycle();
      dac_rst_n = 1'b1;
      ticks = 0;
      for (int k = 1; k <= 20 && ticks == 0; k++) begin
         next_cycle();
         if (dac_tick) ticks = k;
      end
      checkOutput("first_tick_lat", 64'(ticks), 64'd8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
